// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch sequencer
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory, branch unit and decode-facing signals
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        halt_req;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        halted;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc, stall, halt_req,
    output if_valid, if_pc, if_instr, flush, halted, misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc, stall, halt_req,
    input  if_valid, if_pc, if_instr, flush, halted, misalign_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - single-outstanding instruction fetch sequencer
// Issues fetches, presents instructions to decode, and applies redirects/halts.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.master bus
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        kill_q, kill_d;
  logic        halt_pend_q, halt_pend_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic        started_q;

  logic redir_ok, redir_bad, accept;

  assign redir_ok  = bus.redirect_valid && word_aligned(bus.redirect_pc[1:0]);
  assign redir_bad = bus.redirect_valid && !word_aligned(bus.redirect_pc[1:0]);
  // started_q keeps imem_req low until the first edge after reset release
  assign accept    = (state_q == ST_FETCH) && started_q && bus.imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= 32'h0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
      kill_q       <= 1'b0;
      halt_pend_q  <= 1'b0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      kill_q       <= kill_d;
      halt_pend_q  <= halt_pend_d;
      flush_q      <= flush_d;
      misalign_q   <= misalign_d;
      started_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    kill_d       = kill_q;
    halt_pend_d  = halt_pend_q;
    flush_d      = 1'b0;
    misalign_d   = misalign_q;

    unique case (state_q)
      ST_FETCH: begin
        if (accept) begin
          req_addr_d = pc_q;
          state_d    = ST_WAIT;
        end
        if (redir_bad) begin
          misalign_d = 1'b1;
          flush_d    = 1'b1;
          state_d    = ST_HALTED;
        end else if (redir_ok) begin
          pc_d    = bus.redirect_pc;
          flush_d = 1'b1;
          kill_d  = accept;
        end else if (bus.halt_req) begin
          if (accept) halt_pend_d = 1'b1;
          else        state_d     = ST_HALTED;
        end
      end

      ST_WAIT: begin
        if (redir_bad) begin
          misalign_d = 1'b1;
          flush_d    = 1'b1;
          state_d    = ST_HALTED;
        end else if (redir_ok) begin
          pc_d    = bus.redirect_pc;
          flush_d = 1'b1;
          if (bus.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = halt_pend_q ? ST_HALTED : ST_FETCH;
          end else begin
            kill_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          kill_d = 1'b0;
          if (bus.halt_req || halt_pend_q) begin
            state_d = ST_HALTED;
          end else if (kill_q) begin
            state_d = ST_FETCH;
          end else begin
            pc_d         = next_seq_pc(req_addr_q);
            hold_pc_d    = req_addr_q;
            hold_instr_d = bus.imem_rdata;
            state_d      = bus.stall ? ST_HOLD : ST_FETCH;
          end
        end else if (bus.halt_req) begin
          halt_pend_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redir_bad) begin
          misalign_d = 1'b1;
          flush_d    = 1'b1;
          state_d    = ST_HALTED;
        end else if (redir_ok) begin
          pc_d    = bus.redirect_pc;
          flush_d = 1'b1;
          state_d = ST_FETCH;
        end else if (bus.halt_req) begin
          state_d = ST_HALTED;
        end else if (!bus.stall) begin
          state_d = ST_FETCH;
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    bus.imem_req     = (state_q == ST_FETCH) && started_q;
    bus.imem_addr    = {pc_q[31:2], 2'b00};
    bus.if_valid     = 1'b0;
    bus.if_pc        = hold_pc_q;
    bus.if_instr     = hold_instr_q;
    bus.flush        = flush_q;
    bus.halted       = (state_q == ST_HALTED);
    bus.misalign_err = misalign_q;

    if (state_q == ST_WAIT) begin
      bus.if_pc    = req_addr_q;
      bus.if_instr = bus.imem_rdata;
      bus.if_valid = bus.imem_rvalid && !bus.redirect_valid && !kill_q
                     && !halt_pend_q && !bus.halt_req;
    end else if (state_q == ST_HOLD) begin
      bus.if_valid = !bus.redirect_valid && !bus.halt_req;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imem_ready     = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.stall          = 1'b0;
    bus.halt_req       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'b0, bus.imem_req}, 32'd0);
    step();
  endtask

  task automatic expect_fetch(input logic [31:0] addr);
    bus.imem_ready = 1'b1;
    #1;
    chk("fetch_req", {31'b0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, addr);
    step();
    bus.imem_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] addr, input logic stall_in);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = mem(addr);
    bus.stall       = stall_in;
    #1;
    chk("pres_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("pres_pc", bus.if_pc, addr);
    chk("pres_instr", bus.if_instr, mem(addr));
    chk("pres_noreq", {31'b0, bus.imem_req}, 32'd0);
    step();
    bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset state and straight-line fetch 0,4,8
    do_reset();
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_flush", {31'b0, bus.flush}, 32'd0);
    chk("rst_mis", {31'b0, bus.misalign_err}, 32'd0);
    expect_fetch(32'h0);
    respond(32'h0, 1'b0);
    expect_fetch(32'h4);
    respond(32'h4, 1'b0);
    expect_fetch(32'h8);
    respond(32'h8, 1'b0);
    expect_fetch(32'hC);

    // Reset mid-WAIT, then stall three cycles at pc 0x4
    do_reset();
    expect_fetch(32'h0);
    respond(32'h0, 1'b0);
    expect_fetch(32'h4);
    respond(32'h4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.stall = (i < 2);
      #1;
      chk("hold_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("hold_pc", bus.if_pc, 32'h4);
      chk("hold_instr", bus.if_instr, mem(32'h4));
      chk("hold_noreq", {31'b0, bus.imem_req}, 32'd0);
      step();
    end
    bus.stall = 1'b0;
    #1;
    chk("post_hold_valid", {31'b0, bus.if_valid}, 32'd0);
    expect_fetch(32'h8);

    // Redirect to 0x100 while waiting on 0x8
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk("rd_wait_valid", {31'b0, bus.if_valid}, 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd_wait_flush", {31'b0, bus.flush}, 32'd1);
    chk("rd_wait_noreq", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = mem(32'h8);
    #1;
    chk("rd_drop_valid", {31'b0, bus.if_valid}, 32'd0);
    step();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("rd_flush_end", {31'b0, bus.flush}, 32'd0);
    expect_fetch(32'h100);
    respond(32'h100, 1'b0);

    // Redirect coincident with response
    expect_fetch(32'h104);
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = mem(32'h104);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("rd_rv_valid", {31'b0, bus.if_valid}, 32'd0);
    step();
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd_rv_flush", {31'b0, bus.flush}, 32'd1);
    expect_fetch(32'h200);
    respond(32'h200, 1'b0);

    // Redirect coincident with request acceptance
    bus.imem_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    #1;
    chk("rd_acc_addr", bus.imem_addr, 32'h204);
    step();
    bus.imem_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd_acc_flush", {31'b0, bus.flush}, 32'd1);
    chk("rd_acc_noreq", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = mem(32'h204);
    #1;
    chk("rd_acc_drop", {31'b0, bus.if_valid}, 32'd0);
    step();
    bus.imem_rvalid = 1'b0;
    expect_fetch(32'h300);
    respond(32'h300, 1'b0);

    // Wrap from 0xFFFF_FFFC, then halt while waiting
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    expect_fetch(32'hFFFF_FFFC);
    respond(32'hFFFF_FFFC, 1'b0);
    expect_fetch(32'h0000_0000);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    #1;
    chk("halt_pend_noh", {31'b0, bus.halted}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = mem(32'h0);
    #1;
    chk("halt_drop", {31'b0, bus.if_valid}, 32'd0);
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_state", {31'b0, bus.halted}, 32'd1);
      chk("halt_noreq", {31'b0, bus.imem_req}, 32'd0);
      step();
    end

    // Misaligned redirect
    do_reset();
    expect_fetch(32'h0);
    respond(32'h0, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    #1;
    chk("mis_before", {31'b0, bus.misalign_err}, 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_ready     = 1'b1;
    #1;
    chk("mis_err", {31'b0, bus.misalign_err}, 32'd1);
    chk("mis_flush", {31'b0, bus.flush}, 32'd1);
    chk("mis_halted", {31'b0, bus.halted}, 32'd1);
    chk("mis_noreq", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("mis_flush_end", {31'b0, bus.flush}, 32'd0);
    chk("mis_sticky", {31'b0, bus.misalign_err}, 32'd1);
    chk("mis_noreq2", {31'b0, bus.imem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
